// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 codes, MEM FSM states, writeback selects,
// plus helpers that classify access size and alignment.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_REQ  = 2'd1;
  localparam logic [1:0] MS_WAIT = 2'd2;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  // Unsigned funct3 codes are only legal for loads; for stores they fall back to word.
  function automatic acc_size_e acc_size(input logic [2:0] f3, input logic is_store);
    acc_size_e sz;
    sz = SZ_WORD;
    if (f3 == F3_B || (!is_store && f3 == F3_BU))
      sz = SZ_BYTE;
    else if (f3 == F3_H || (!is_store && f3 == F3_HU))
      sz = SZ_HALF;
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store data,
// shifted and sign/zero-extended load data, and the misalignment flag.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  acc_size_e   sz;
  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    sz         = acc_size(funct3_i, is_store_i);
    misalign_o = misaligned(sz, off_i);
    shifted    = rdata_i >> {off_i, 3'b000};
    sext       = ~funct3_i[2];
    be_o       = 4'b1111;
    wdata_o    = sdata_i;
    load_o     = shifted;
    case (sz)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        load_o  = {{24{shifted[7] & sext}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{sdata_i[15:0]}};
        load_o  = {{16{shifted[15] & sext}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage of the 5-stage RV32I pipeline: EX/MEM register, data-memory request/grant/response
// FSM, lane steering and load extension, and the stall towards the hazard unit.
module mem_stage_unit
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_ALU_out,
  input  logic [XLEN-1:0] ex_ForwardDataB,
  input  logic            ex_MemEn,
  input  logic            ex_MemRW,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_RegWEn,
  input  logic [4:0]      ex_rd,
  input  logic [1:0]      ex_WBSel,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_ALU_out,
  output logic [4:0]      mem_rd,
  output logic            mem_RegWEn,
  output logic [1:0]      mem_WBSel,
  output logic [XLEN-1:0] mem_LoadData,
  output logic            mem_stall,
  output logic            mem_misalign,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  logic            valid_q, memen_q, memrw_q, regwen_q;
  logic [XLEN-1:0] pc_q, alu_q, sdata_q, ldata_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [1:0]      wbsel_q;
  logic [1:0]      state_q, state_d;

  logic [3:0]      be;
  logic [XLEN-1:0] wdata, ld_ext;
  logic            misalign, start_ex, ld_done;

  // An aligned memory op entering MEM starts its request on the same edge it is registered.
  assign start_ex  = ex_valid && ex_MemEn &&
                     !misaligned(acc_size(ex_funct3, ex_MemRW), ex_ALU_out[1:0]);
  assign ld_done   = (state_q == MS_WAIT) && dmem_rvalid;
  assign mem_stall = (state_q == MS_REQ) || ((state_q == MS_WAIT) && !dmem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      alu_q    <= '0;
      sdata_q  <= '0;
      memen_q  <= 1'b0;
      memrw_q  <= 1'b0;
      funct3_q <= '0;
      regwen_q <= 1'b0;
      rd_q     <= '0;
      wbsel_q  <= '0;
    end else if (!mem_stall) begin
      valid_q  <= ex_valid;
      pc_q     <= ex_pc;
      alu_q    <= ex_ALU_out;
      sdata_q  <= ex_ForwardDataB;
      memen_q  <= ex_valid & ex_MemEn;
      memrw_q  <= ex_valid & ex_MemRW;
      funct3_q <= ex_valid ? ex_funct3 : 3'b000;
      regwen_q <= ex_valid & ex_RegWEn;
      rd_q     <= ex_valid ? ex_rd : 5'd0;
      wbsel_q  <= ex_valid ? ex_WBSel : 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: state_d = start_ex ? MS_REQ : MS_IDLE;
      MS_REQ:  if (dmem_gnt) state_d = memrw_q ? MS_IDLE : MS_WAIT;
      MS_WAIT: if (dmem_rvalid) state_d = start_ex ? MS_REQ : MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MS_IDLE;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_done)
        ldata_q <= ld_ext;
    end
  end

  load_store_align u_align (
    .funct3_i   (funct3_q),
    .is_store_i (memrw_q),
    .off_i      (alu_q[1:0]),
    .sdata_i    (sdata_q),
    .rdata_i    (dmem_rdata),
    .be_o       (be),
    .wdata_o    (wdata),
    .load_o     (ld_ext),
    .misalign_o (misalign)
  );

  // Load data is bypassed in the rvalid cycle so it is valid the moment the stall drops.
  assign mem_LoadData = ld_done ? ld_ext : ldata_q;
  assign mem_valid    = valid_q;
  assign mem_pc       = pc_q;
  assign mem_ALU_out  = alu_q;
  assign mem_rd       = rd_q;
  assign mem_WBSel    = wbsel_q;
  assign mem_misalign = valid_q && memen_q && misalign;
  assign mem_RegWEn   = valid_q && regwen_q && !mem_misalign;
  assign dmem_req     = (state_q == MS_REQ);
  assign dmem_we      = dmem_req && memrw_q;
  assign dmem_addr    = {alu_q[XLEN-1:2], 2'b00};
  assign dmem_be      = dmem_req ? be : 4'b0000;
  assign dmem_wdata   = dmem_req ? wdata : '0;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: hand-computed vectors for ALU pass-through, stores, loads,
// misalignment, back-to-back load/store and reset during an outstanding load.
module tb_mem_stage_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_MemEn, ex_MemRW, ex_RegWEn;
  logic [31:0] ex_pc, ex_ALU_out, ex_ForwardDataB;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_WBSel;
  logic        mem_valid, mem_RegWEn, mem_stall, mem_misalign;
  logic [31:0] mem_pc, mem_ALU_out, mem_LoadData;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_WBSel;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ALU_out(ex_ALU_out),
    .ex_ForwardDataB(ex_ForwardDataB), .ex_MemEn(ex_MemEn), .ex_MemRW(ex_MemRW),
    .ex_funct3(ex_funct3), .ex_RegWEn(ex_RegWEn), .ex_rd(ex_rd), .ex_WBSel(ex_WBSel),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_ALU_out(mem_ALU_out), .mem_rd(mem_rd),
    .mem_RegWEn(mem_RegWEn), .mem_WBSel(mem_WBSel), .mem_LoadData(mem_LoadData),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                          input logic men, input logic rw, input logic [2:0] f3,
                          input logic rwen, input logic [4:0] rd, input logic [1:0] wb);
    ex_valid = 1'b1; ex_pc = pc; ex_ALU_out = alu; ex_ForwardDataB = sd;
    ex_MemEn = men; ex_MemRW = rw; ex_funct3 = f3; ex_RegWEn = rwen; ex_rd = rd; ex_WBSel = wb;
  endtask

  task automatic bubble();
    ex_valid = 1'b0; ex_pc = '0; ex_ALU_out = '0; ex_ForwardDataB = '0;
    ex_MemEn = 1'b0; ex_MemRW = 1'b0; ex_funct3 = '0; ex_RegWEn = 1'b0; ex_rd = '0; ex_WBSel = '0;
  endtask

  // Store issued with gnt after gwait extra REQ cycles; stall must last gwait+1 cycles.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input int gwait, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int stalls = 0;
    @(negedge clk); drive_ex(32'h20, addr, sd, 1'b1, 1'b1, f3, 1'b0, 5'd0, WB_ALU);
    @(negedge clk); bubble();
    for (int i = 0; i <= gwait; i++) begin
      if (i > 0) @(negedge clk);
      dmem_gnt = (i == gwait);
      #1;
      if (mem_stall) stalls++;
    end
    chk({tag, "_req"},   dmem_req,   1);
    chk({tag, "_we"},    dmem_we,    1);
    chk({tag, "_addr"},  dmem_addr,  exp_addr);
    chk({tag, "_be"},    dmem_be,    exp_be);
    chk({tag, "_wdata"}, dmem_wdata, exp_wd);
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk({tag, "_req_off"}, dmem_req, 0);
    chk({tag, "_stall_off"}, mem_stall, 0);
    chk({tag, "_stall_cyc"}, stalls, gwait + 1);
  endtask

  // Load with gnt after gwait extra REQ cycles and rvalid after rwait idle WAIT cycles.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int gwait, input int rwait,
                         input logic [31:0] exp, input int exp_stall);
    int stalls = 0;
    @(negedge clk); drive_ex(32'h30, addr, 32'h0, 1'b1, 1'b0, f3, 1'b1, 5'd7, WB_MEM);
    @(negedge clk); bubble();
    for (int i = 0; i <= gwait; i++) begin
      if (i > 0) @(negedge clk);
      dmem_gnt = (i == gwait);
      #1;
      if (mem_stall) stalls++;
    end
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_we"},   dmem_we,   0);
    for (int i = 0; i <= rwait; i++) begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = (i == rwait);
      dmem_rdata = (i == rwait) ? word : 32'hDEAD_BEEF;
      #1;
      if (mem_stall) stalls++;
    end
    chk({tag, "_data"},  mem_LoadData, exp);
    chk({tag, "_rwen"},  mem_RegWEn,   1);
    chk({tag, "_stall"}, stalls,       exp_stall);
    @(negedge clk); dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk({tag, "_hold"}, mem_LoadData, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_pc",    mem_pc,    RST_PC);
    chk("rst_stall", mem_stall, 0);
    chk("rst_req",   dmem_req,  0);
    chk("rst_be",    dmem_be,   0);
    chk("rst_ld",    mem_LoadData, 0);
    @(negedge clk); rst_n = 1'b1;

    // ALU pass-through
    @(negedge clk); drive_ex(32'h10, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, WB_ALU);
    @(negedge clk); bubble(); #1;
    chk("alu_out",   mem_ALU_out, 32'h1234);
    chk("alu_stall", mem_stall,   0);
    chk("alu_req",   dmem_req,    0);
    chk("alu_rwen",  mem_RegWEn,  1);
    chk("alu_rd",    mem_rd,      5);
    chk("alu_pc",    mem_pc,      32'h10);

    do_store("sb", F3_B, 32'h103, 32'h0000_00AB, 0, 32'h100, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", F3_H, 32'h012, 32'h1234_BEEF, 1, 32'h010, 4'b1100, 32'hBEEF_BEEF);

    do_load("lb",  F3_B,  32'h102, 32'h0080_0000, 2, 1, 32'hFFFF_FF80, 4);
    do_load("lbu", F3_BU, 32'h102, 32'h0080_0000, 1, 0, 32'h0000_0080, 2);
    do_load("lhu", F3_HU, 32'h106, 32'h8001_0000, 0, 1, 32'h0000_8001, 2);

    // Misaligned word load
    @(negedge clk); drive_ex(32'h50, 32'h202, 32'h0, 1'b1, 1'b0, F3_W, 1'b1, 5'd9, WB_MEM);
    @(negedge clk); bubble(); #1;
    chk("mis_pulse", mem_misalign, 1);
    chk("mis_req",   dmem_req,     0);
    chk("mis_rwen",  mem_RegWEn,   0);
    chk("mis_stall", mem_stall,    0);
    @(negedge clk); #1;
    chk("mis_clear", mem_misalign, 0);
    chk("mis_noreq", dmem_req,     0);

    // LH followed by SW held in EX while LH stalls
    @(negedge clk); drive_ex(32'h40, 32'h106, 32'h0, 1'b1, 1'b0, F3_H, 1'b1, 5'd3, WB_MEM);
    @(negedge clk); drive_ex(32'h44, 32'h204, 32'hCAFE_F00D, 1'b1, 1'b1, F3_W, 1'b0, 5'd0, WB_ALU);
    dmem_gnt = 1'b0; #1;
    chk("b2b_lh_req", dmem_req, 1);
    chk("b2b_pc_c1",  mem_pc,   32'h40);
    @(negedge clk); dmem_gnt = 1'b1; #1;
    chk("b2b_pc_c2",  mem_pc,   32'h40);
    @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000; #1;
    chk("b2b_lh_data",  mem_LoadData, 32'hFFFF_8001);
    chk("b2b_lh_stall", mem_stall,    0);
    chk("b2b_pc_c3",    mem_pc,       32'h40);
    @(negedge clk); bubble(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0; dmem_gnt = 1'b1; #1;
    chk("b2b_sw_req",   dmem_req,   1);
    chk("b2b_sw_we",    dmem_we,    1);
    chk("b2b_sw_addr",  dmem_addr,  32'h204);
    chk("b2b_sw_be",    dmem_be,    4'b1111);
    chk("b2b_sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("b2b_sw_pc",    mem_pc,     32'h44);
    chk("b2b_ld_hold",  mem_LoadData, 32'hFFFF_8001);
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk("b2b_done", mem_stall, 0);

    // Reset while a load waits for rvalid
    @(negedge clk); drive_ex(32'h60, 32'h300, 32'h0, 1'b1, 1'b0, F3_W, 1'b1, 5'd4, WB_MEM);
    @(negedge clk); bubble(); dmem_gnt = 1'b1;
    @(negedge clk); dmem_gnt = 1'b0; #1;
    chk("rw_wait_stall", mem_stall, 1);
    rst_n = 1'b0; #1;
    chk("rw_stall", mem_stall,    0);
    chk("rw_req",   dmem_req,     0);
    chk("rw_valid", mem_valid,    0);
    chk("rw_pc",    mem_pc,       RST_PC);
    chk("rw_ld",    mem_LoadData, 0);
    chk("rw_rwen",  mem_RegWEn,   0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678; #1;
    chk("rw_stray_ld",    mem_LoadData, 0);
    chk("rw_stray_stall", mem_stall,    0);
    @(negedge clk); dmem_rvalid = 1'b0; #1;
    chk("rw_after_ld", mem_LoadData, 0);
    chk("rw_after_req", dmem_req,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
